// File: rtl/tree_dispatch_stage.sv
// tree_dispatch_stage: 2-deep FIFO feeding NUM_CHILD children by strict round-robin unicast or all-child broadcast.
module tree_dispatch_stage #(
  parameter int NUM_CHILD = 15,
  parameter int DATA_W    = 32,
  parameter int PTR_W     = $clog2(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_bcast,
  output logic [NUM_CHILD-1:0] out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic [NUM_CHILD-1:0] out_ready,
  output logic [PTR_W-1:0]     rr_ptr,
  output logic                 busy,
  output logic [15:0]          dispatch_cnt
);
  typedef enum logic [1:0] {IDLE, UNI, BC} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0]    mem_data [2];
  logic [1:0]           mem_bc;
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count, count_nxt;
  logic [NUM_CHILD-1:0] pending, pend_left;
  logic                 push, done, head_bc_nxt;
  assign in_ready    = (count != 2'd2) & ~rst;
  assign push        = in_valid & in_ready;
  assign pend_left   = pending & ~out_ready;
  assign done        = (state == UNI) ? out_ready[rr_ptr] : (state == BC) && (pend_left == '0);
  assign count_nxt   = count + 2'(push) - 2'(done);
  // Head after this edge: the pushed item if the FIFO would otherwise be empty
  assign head_bc_nxt = (count == 2'(done)) ? in_bcast : mem_bc[rd_ptr ^ done];
  assign busy        = (state != IDLE) | (count != 2'd0);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (state != IDLE && !done) ? state :
                (count_nxt == 2'd0) ? IDLE : head_bc_nxt ? BC : UNI;
  always_comb begin
    out_valid = (state == UNI) ? NUM_CHILD'(1) << rr_ptr : (state == BC) ? pending : '0;
    out_data  = (state == IDLE) ? '0 : mem_data[rd_ptr];
  end
  always_ff @(posedge clk)
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_bc[wr_ptr]   <= in_bcast;
    end
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      pending      <= '0;
      rr_ptr       <= '0;
      dispatch_cnt <= 16'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (done) rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      pending <= (state_nxt != BC) ? '0 : (state == BC && !done) ? pend_left : '1;
      if (done) dispatch_cnt <= dispatch_cnt + 16'd1;
      if (done && state == UNI) rr_ptr <= (rr_ptr == PTR_W'(NUM_CHILD - 1)) ? '0 : rr_ptr + 1'b1;
    end
endmodule

// File: doc/tree_dispatch_stage.md
# tree_dispatch_stage

Round-robin / broadcast dispatcher that sits directly upstream of a generated hierarchy node and feeds its fixed set of child instances (15 children, inst_0..inst_14) from a single valid/ready input stream. Items are buffered in a 2-entry FIFO and delivered either to exactly one child in strict rotating order (unicast) or to every child (broadcast). Broadcast completes only after each child has accepted once. A wrapping counter reports the number of completed dispatches.

## Interface
Parameters:
- NUM_CHILD, 15: number of downstream child instances (2..32)
- DATA_W, 32: payload width
- PTR_W, $clog2(NUM_CHILD): round-robin pointer width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream item valid
- in_ready  out  1  upstream may transfer (in_valid & in_ready at an edge)
- in_data  in  DATA_W  item payload
- in_bcast  in  1  1 = broadcast item, 0 = unicast item; sampled with in_data
- out_valid  out  NUM_CHILD  per-child valid
- out_data  out  DATA_W  shared payload to all children
- out_ready  in  NUM_CHILD  per-child ready
- rr_ptr  out  PTR_W  index of the next unicast target
- busy  out  1  FSM not IDLE or FIFO non-empty
- dispatch_cnt  out  16  completed dispatches, wraps 0xFFFF -> 0

## Operation
- FIFO: depth 2, stores {bcast, data}. in_ready = (occupancy < 2) & ~rst. Push and pop in the same edge are legal.
- FSM states:
  - IDLE: out_valid = 0.
  - UNI: out_valid = one-hot at rr_ptr; out_data = head data.
  - BC: out_valid = pending mask; out_data = head data.
- IDLE -> UNI/BC when the FIFO is non-empty, or when a push occurs into an empty FIFO. The choice follows the head's bcast bit. On entry to BC, pending is loaded with all NUM_CHILD bits set.
- UNI completes at an edge where out_ready[rr_ptr] = 1. Completion pops the head and advances rr_ptr by 1, wrapping NUM_CHILD-1 -> 0. Busy children are never skipped: strict order.
- BC: each edge, pending &= ~out_ready. BC completes at the edge where pending & ~out_ready becomes 0. Completion pops the head; rr_ptr is unchanged.
- On completion:
  - dispatch_cnt increments by 1, once per item regardless of mode.
  - Next state is UNI/BC from the next head if one remains after the pop (no bubble), else IDLE.
- out_valid bits never drop before their handshake. out_data is stable while any out_valid bit is high.
- A child whose out_ready is high with its out_valid low is ignored.

## Timing
- Reset values: in_ready = 0 while rst = 1, then 1 from the first cycle after rst deasserts. out_valid = 0, out_data = 0, rr_ptr = 0, dispatch_cnt = 0, busy = 0, FIFO empty, pending = 0, state IDLE.
- Latency: an item accepted at edge N with an empty FIFO and IDLE state has out_valid asserted in the cycle after edge N. A child ready in that cycle completes at edge N+1.
- Throughput: with the target ready continuously, unicast sustains 1 item/cycle.
- Broadcast takes at least 1 cycle and at most until the last child accepts.
- Full FIFO: in_ready = 0. A pop at edge N makes in_ready = 1 in the cycle after N. A push is not accepted in the same cycle as a full-FIFO pop.
- Reset mid-operation: rst high at any edge discards FIFO contents and the in-flight item, with no dispatch_cnt increment. Reset has priority over all simultaneous handshakes.
- Counter wrap: 0xFFFF + 1 -> 0x0000, with no flag.

## Test plan
- Reset, then 3 unicast items D0..D2 with all out_ready = 1 -> out_valid = 0x0001, 0x0002, 0x0004 on consecutive cycles; rr_ptr ends at 3; dispatch_cnt = 3.
- 16 unicast items, all ready -> the item at index 15 goes to child 0 (wrap); rr_ptr = 1; dispatch_cnt = 16.
- Broadcast 0xA5A5_0001 with children 0..6 ready in cycle 1 and 7..14 ready in cycle 3 -> pending 0x7F80 after the first edge; completes at the third edge; rr_ptr unchanged; dispatch_cnt += 1.
- Child 2 not ready, with rr_ptr = 2, while 3 items are pushed -> in_ready low after 2 buffered items; out_valid stays 0x0004 with out_data stable; no skip to child 3.
- Unicast, then broadcast, then unicast back-to-back, all ready -> no IDLE bubble between items; dispatch_cnt = 3.
- rst asserted mid-broadcast (pending = 0x0F00) -> next cycle: out_valid = 0, dispatch_cnt = 0, rr_ptr = 0, busy = 0; in_ready = 1 the cycle after rst drops.
